ibus_bridge: RTL

CPU-side bridge sitting directly upstream of the systolic I/O buffer (iobuf). It turns single-word RV32I load/store requests into the 16-bit ibus protocol: write pulses, and reads with a fixed 2-cycle return latency. It also polls the array run status in the background after a start write, and raises a sticky done interrupt when the array finishes.

---
 rtl/ibus_bridge.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ibus_bridge.sv
// CPU-to-ibus bridge: single-word loads/stores, 2-cycle ibus read latency, background run-status polling and a sticky done irq.
// Optional build macro IBUS_SIGNEXT_EN: sign-extend 16-bit load data instead of zero-extending.
module ibus_bridge #(
  parameter int POLL_INT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [17:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        irq,
  output logic        ren,
  output logic [15:0] ibus_radr,
  input  logic [15:0] ibus_rdata,
  output logic        wen,
  output logic [15:0] ibus_wadr,
  output logic [15:0] ibus_wdata
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR     = 3'd1;
  localparam logic [2:0] ST_RD_ISS = 3'd2;
  localparam logic [2:0] ST_RD_W   = 3'd3;
  localparam logic [2:0] ST_RD_CAP = 3'd4;
  localparam logic [2:0] ST_ACK    = 3'd5;
  localparam logic [2:0] ST_LOC    = 3'd6;

  localparam logic [15:0] ADR_START = 16'hFFF0;
  localparam logic [15:0] ADR_IRQ   = 16'hFFF3;
  localparam logic [7:0]  TMR_MAX   = 8'(POLL_INT - 1);

  logic [2:0]  state_r;
  logic        busy_r;
  logic        poll_r;
  logic        loc_we_r;
  logic [7:0]  timer_r;
  logic        cpu_ack_r;
  logic [31:0] cpu_rdata_r;
  logic        irq_r;
  logic        ren_r;
  logic [15:0] ibus_radr_r;
  logic        wen_r;
  logic [15:0] ibus_wadr_r;
  logic [15:0] ibus_wdata_r;

  logic [15:0] cpu_iadr_s;
  logic        poll_due_s;
  logic [31:0] rd_ext_s;
  logic        unused_bits_s;

  // Request address decode, poll-due flag and load-data extension.
  always_comb begin
    cpu_iadr_s    = cpu_adr[17:2];
    poll_due_s    = busy_r && (timer_r == TMR_MAX);
    unused_bits_s = ^{cpu_adr[1:0], cpu_wdata[31:16]};
`ifdef IBUS_SIGNEXT_EN
    rd_ext_s = {{16{ibus_rdata[15]}}, ibus_rdata};
`else
    rd_ext_s = {16'd0, ibus_rdata};
`endif
  end

  // Transaction FSM, poll timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      poll_r       <= 1'b0;
      loc_we_r     <= 1'b0;
      timer_r      <= 8'd0;
      cpu_ack_r    <= 1'b0;
      cpu_rdata_r  <= 32'd0;
      irq_r        <= 1'b0;
      ren_r        <= 1'b0;
      ibus_radr_r  <= 16'd0;
      wen_r        <= 1'b0;
      ibus_wadr_r  <= 16'd0;
      ibus_wdata_r <= 16'd0;
    end else begin
      cpu_ack_r   <= 1'b0;
      cpu_rdata_r <= 32'd0;
      ren_r       <= 1'b0;
      wen_r       <= 1'b0;
      // Timer only advances while idle so the poll interval excludes the poll's own read.
      if (busy_r && (state_r == ST_IDLE) && (timer_r != TMR_MAX)) begin
        timer_r <= timer_r + 8'd1;
      end else begin
        timer_r <= timer_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (cpu_cs) begin
            if (cpu_iadr_s == ADR_IRQ) begin
              state_r     <= ST_LOC;
              cpu_ack_r   <= 1'b1;
              loc_we_r    <= cpu_we;
              cpu_rdata_r <= cpu_we ? 32'd0 : {31'd0, irq_r};
            end else if (cpu_we) begin
              state_r      <= ST_WR;
              wen_r        <= 1'b1;
              cpu_ack_r    <= 1'b1;
              ibus_wadr_r  <= cpu_iadr_s;
              ibus_wdata_r <= cpu_wdata[15:0];
              if (cpu_iadr_s == ADR_START) begin
                busy_r  <= 1'b1;
                timer_r <= 8'd0;
              end else begin
                busy_r <= busy_r;
              end
            end else begin
              state_r     <= ST_RD_ISS;
              ren_r       <= 1'b1;
              ibus_radr_r <= cpu_iadr_s;
              poll_r      <= 1'b0;
            end
          end else if (poll_due_s) begin
            state_r     <= ST_RD_ISS;
            ren_r       <= 1'b1;
            ibus_radr_r <= ADR_START;
            poll_r      <= 1'b1;
            timer_r     <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR:     state_r <= ST_IDLE;
        ST_RD_ISS: state_r <= ST_RD_W;
        ST_RD_W:   state_r <= ST_RD_CAP;
        ST_RD_CAP: begin
          state_r <= ST_ACK;
          if (poll_r) begin
            if (!ibus_rdata[0]) begin
              busy_r <= 1'b0;
              irq_r  <= 1'b1;
            end else begin
              busy_r <= busy_r;
            end
          end else begin
            cpu_ack_r   <= 1'b1;
            cpu_rdata_r <= rd_ext_s;
          end
        end
        ST_ACK:    state_r <= ST_IDLE;
        ST_LOC: begin
          state_r <= ST_IDLE;
          if (loc_we_r) begin
            irq_r <= 1'b0;
          end else begin
            irq_r <= irq_r;
          end
        end
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ack    = cpu_ack_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign irq        = irq_r;
  assign ren        = ren_r;
  assign ibus_radr  = ibus_radr_r;
  assign wen        = wen_r;
  assign ibus_wadr  = ibus_wadr_r;
  assign ibus_wdata = ibus_wdata_r;

endmodule
